// File: rtl/umi_pkg.sv
// Shared UMI definitions: opcodes and packet field placement.
package umi_pkg;

  localparam logic [7:0] UMI_OP_WRITE = 8'h01;
  localparam logic [7:0] UMI_OP_READ  = 8'h08;

  // Packet layout: command word in the low 32 bits, then addresses, then data.
  localparam int unsigned UMI_OPCODE_LSB = 0;
  localparam int unsigned UMI_SIZE_LSB   = 8;
  localparam int unsigned UMI_SIZE_W     = 3;
  localparam int unsigned UMI_USER_LSB   = 12;
  localparam int unsigned UMI_BURST_BIT  = 20;
  localparam int unsigned UMI_DST_LSB    = 32;
  localparam int unsigned UMI_SRC_LSB    = 96;
  localparam int unsigned UMI_ADDR_W     = 64;
  localparam int unsigned UMI_DATA_LSB   = 160;
  localparam int unsigned UMI_DATA_W     = 96;

endpackage

// File: rtl/umi_pack.sv
// Assembles a UMI packet from its fields; unused bits are zero.
module umi_pack
  import umi_pkg::*;
(
  input  logic [7:0]              opcode_i,
  input  logic [UMI_SIZE_W-1:0]   size_i,
  input  logic [7:0]              user_i,
  input  logic                    burst_i,
  input  logic [UMI_ADDR_W-1:0]   dstaddr_i,
  input  logic [UMI_ADDR_W-1:0]   srcaddr_i,
  input  logic [255:0]            data_i,
  output logic [255:0]            packet_o
);

  logic unused_data;
  assign unused_data = ^data_i[255:UMI_DATA_W];

  // Place each field at its fixed offset.
  always_comb begin
    packet_o = '0;
    packet_o[UMI_OPCODE_LSB +: 8]          = opcode_i;
    packet_o[UMI_SIZE_LSB +: UMI_SIZE_W]   = size_i;
    packet_o[UMI_USER_LSB +: 8]            = user_i;
    packet_o[UMI_BURST_BIT]                = burst_i;
    packet_o[UMI_DST_LSB +: UMI_ADDR_W]    = dstaddr_i;
    packet_o[UMI_SRC_LSB +: UMI_ADDR_W]    = srcaddr_i;
    packet_o[UMI_DATA_LSB +: UMI_DATA_W]   = data_i[UMI_DATA_W-1:0];
  end

endmodule

// File: rtl/umi_resp_ram.sv
// Single-port synchronous RAM with byte write enables and registered read.
module umi_resp_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [DW/8-1:0]          we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Byte-lane writes; a cycle with no lane enabled is a read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < DW / 8; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/umi_unpack.sv
// Splits a UMI packet into its fields; data is zero-extended to 256 bits.
module umi_unpack
  import umi_pkg::*;
(
  input  logic [255:0]            packet_i,
  output logic [7:0]              opcode_o,
  output logic [UMI_SIZE_W-1:0]   size_o,
  output logic [7:0]              user_o,
  output logic                    burst_o,
  output logic [UMI_ADDR_W-1:0]   dstaddr_o,
  output logic [UMI_ADDR_W-1:0]   srcaddr_o,
  output logic [255:0]            data_o
);

  assign opcode_o  = packet_i[UMI_OPCODE_LSB +: 8];
  assign size_o    = packet_i[UMI_SIZE_LSB +: UMI_SIZE_W];
  assign user_o    = packet_i[UMI_USER_LSB +: 8];
  assign burst_o   = packet_i[UMI_BURST_BIT];
  assign dstaddr_o = packet_i[UMI_DST_LSB +: UMI_ADDR_W];
  assign srcaddr_o = packet_i[UMI_SRC_LSB +: UMI_ADDR_W];
  assign data_o    = 256'(packet_i[UMI_DATA_LSB +: UMI_DATA_W]);

endmodule

// File: rtl/umi_mem_responder.sv
// UMI memory target: services one request at a time against a local byte-lane RAM.
module umi_mem_responder
  import umi_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] req_packet,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [255:0] resp_packet,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         err,
  output logic [31:0]  wr_count,
  output logic [31:0]  rd_count
);

  localparam int unsigned LW  = DW / 8;
  localparam int unsigned OW  = $clog2(LW);
  localparam int unsigned OFW = (OW > 0) ? OW : 1;
  localparam int unsigned AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRd, StResp} state_e;

  state_e state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [255:0]          resp_packet_q, resp_packet_d;
  logic                  err_q, err_d;
  logic [31:0]           wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [OFW-1:0]        ofs_q, ofs_d;
  logic [UMI_SIZE_W-1:0] size_q, size_d;
  logic [UMI_ADDR_W-1:0] srcaddr_q, srcaddr_d;

  logic [7:0]            req_opcode, req_user;
  logic [UMI_SIZE_W-1:0] req_size;
  logic                  req_burst;
  logic [UMI_ADDR_W-1:0] req_dstaddr, req_srcaddr;
  logic [255:0]          req_data;

  umi_unpack u_unpack (
    .packet_i  (req_packet),
    .opcode_o  (req_opcode),
    .size_o    (req_size),
    .user_o    (req_user),
    .burst_o   (req_burst),
    .dstaddr_o (req_dstaddr),
    .srcaddr_o (req_srcaddr),
    .data_o    (req_data)
  );

  logic unused_req;
  assign unused_req = ^{req_user, req_data, req_dstaddr};

  logic [31:0]   ofs, nbytes;
  logic          req_err, accept, is_write;
  logic [LW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  // Request decode: lane offset, word index, error checks and write lane mask.
  always_comb begin
    ofs       = 32'(req_dstaddr[OFW-1:0]) & (LW - 1);
    nbytes    = 32'd1 << req_size;
    ram_addr  = AW'(req_dstaddr >> OW);
    req_err   = !(req_opcode == UMI_OP_WRITE || req_opcode == UMI_OP_READ) || req_burst ||
                (nbytes > LW) || ((ofs & (nbytes - 1)) != '0);
    accept    = req_valid && (state_q == StIdle);
    is_write  = req_opcode == UMI_OP_WRITE;
    ram_wdata = DW'(req_data << (8 * ofs));
    ram_we    = '0;
    for (int unsigned i = 0; i < LW; i++) begin
      ram_we[i] = accept && !req_err && is_write && (i >= ofs) && (i < ofs + nbytes);
    end
  end

  umi_resp_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (accept && !req_err),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  logic [31:0]   rd_nbytes;
  logic [DW-1:0] rd_data;
  logic [255:0]  pack_out;

  // Right-justify the requested bytes and clear everything above them.
  always_comb begin
    rd_nbytes = 32'd1 << size_q;
    rd_data   = DW'(ram_rdata >> (8 * ofs_q));
    for (int unsigned i = 0; i < LW; i++) begin
      if (i >= rd_nbytes) rd_data[8*i +: 8] = 8'h00;
    end
  end

  umi_pack u_pack (
    .opcode_i  (UMI_OP_WRITE),
    .size_i    (size_q),
    .user_i    (8'h00),
    .burst_i   (1'b0),
    .dstaddr_i (srcaddr_q),
    .srcaddr_i ('0),
    .data_i    (256'(rd_data)),
    .packet_o  (pack_out)
  );

  // Next-state logic: accept in idle, capture RAM data in RD, wait for handshake in RESP.
  always_comb begin
    state_d       = state_q;
    resp_valid_d  = resp_valid_q;
    resp_packet_d = resp_packet_q;
    err_d         = err_q;
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;
    ofs_d         = ofs_q;
    size_d        = size_q;
    srcaddr_d     = srcaddr_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            err_d = 1'b1;
          end else if (is_write) begin
            wr_count_d = wr_count_q + 32'd1;
          end else begin
            ofs_d     = OFW'(ofs);
            size_d    = req_size;
            srcaddr_d = req_srcaddr;
            state_d   = StRd;
          end
        end
      end
      StRd: begin
        resp_packet_d = pack_out;
        resp_valid_d  = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rd_count_d   = rd_count_q + 32'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      resp_valid_q  <= 1'b0;
      resp_packet_q <= '0;
      err_q         <= 1'b0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      ofs_q         <= '0;
      size_q        <= '0;
      srcaddr_q     <= '0;
    end else begin
      state_q       <= state_d;
      resp_valid_q  <= resp_valid_d;
      resp_packet_q <= resp_packet_d;
      err_q         <= err_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      ofs_q         <= ofs_d;
      size_q        <= size_d;
      srcaddr_q     <= srcaddr_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = resp_valid_q;
  assign resp_packet = resp_packet_q;
  assign err         = err_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;

endmodule
